// File: rtl/tavg_pkg.sv
// Package: tavg_pkg
// Shared types and constants for the temperature averaging filter.
//   TEMP_W       sample width from TempSensorCtl (13 bits, signed)
//   FRAC_BITS    fractional bits in a sample (1/16 degC LSB)
//   temp_t       signed sample type
//   tavg_state_t filter FSM state (EMPTY until the first sample primes it)
package tavg_pkg;

    localparam int unsigned TEMP_W    = 13;
    localparam int unsigned FRAC_BITS = 4;

    typedef logic signed [TEMP_W-1:0] temp_t;

    typedef enum logic {
        EMPTY,
        RUN
    } tavg_state_t;

endpackage

// File: rtl/temp_avg_filter_if.sv
// Interface: temp_avg_filter_if
// Bundles the sensor-side inputs and display-side outputs of temp_avg_filter.
//   rdy_in, temp_in  sensor ready level and sample
//   clr              synchronous clear back to EMPTY
//   temp_out,out_vld window mean and its one-cycle update strobe
//   primed           at least one sample accepted since reset/clear
//   tmin, tmax       running min/max of the mean (only with TAVG_MINMAX_EN)
// Modports: master drives the inputs and observes outputs; slave is the filter.
interface temp_avg_filter_if;
    import tavg_pkg::*;

    logic  rdy_in;
    temp_t temp_in;
    logic  clr;
    temp_t temp_out;
    logic  out_vld;
    logic  primed;
`ifdef TAVG_MINMAX_EN
    temp_t tmin;
    temp_t tmax;
`endif

    modport master (
        output rdy_in,
        output temp_in,
        output clr,
        input  temp_out,
        input  out_vld,
`ifdef TAVG_MINMAX_EN
        input  tmin,
        input  tmax,
`endif
        input  primed
    );

    modport slave (
        input  rdy_in,
        input  temp_in,
        input  clr,
        output temp_out,
        output out_vld,
`ifdef TAVG_MINMAX_EN
        output tmin,
        output tmax,
`endif
        output primed
    );

endinterface

// File: rtl/tavg_ringbuf.sv
// Module: tavg_ringbuf
// Window storage for the averager: 2**DEPTH_LOG2 entries of temp_t.
//   clk    system clock
//   fill   write wdata into every entry (priming)
//   we     write wdata into entry ptr
//   ptr    write index, also the asynchronous read index
//   wdata  sample to store
//   rdata  entry at ptr (the oldest sample, about to be replaced)
// Contents are not reset; the filter always primes before reading.
module tavg_ringbuf
    import tavg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  fill,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] ptr,
    input  temp_t                 wdata,
    output temp_t                 rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    temp_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= wdata;
            end
        end else if (we) begin
            mem_q[ptr] <= wdata;
        end
    end

    assign rdata = mem_q[ptr];

endmodule

// File: rtl/temp_avg_filter.sv
// Module: temp_avg_filter
// Sliding-window mean of TempSensorCtl readings, used to steady the display.
// A rising edge of rdy_in accepts temp_in; the first sample after reset/clear
// fills the whole window, later samples replace the oldest entry.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    temp_avg_filter_if.slave (rdy_in, temp_in, clr, temp_out, out_vld,
//          primed, and tmin/tmax when enabled)
// Parameters:
//   AVG_LOG2  log2 of window depth (1..5)
// Build option:
//   TAVG_MINMAX_EN  adds running min/max of the averaged value on tmin/tmax.
module temp_avg_filter
    import tavg_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    temp_avg_filter_if.slave   bus
);

    localparam int unsigned SUM_W = TEMP_W + AVG_LOG2;

    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef logic [AVG_LOG2-1:0]      ptr_t;

    tavg_state_t state_q;
    logic        rdy_q;
    sum_t        sum_q;
    ptr_t        wr_ptr_q;
    temp_t       temp_out_q;
    logic        out_vld_q;
    logic        primed_q;
`ifdef TAVG_MINMAX_EN
    temp_t       tmin_q;
    temp_t       tmax_q;
`endif

    logic  accept;
    logic  do_prime;
    logic  do_update;
    temp_t old_sample;
    sum_t  old_ext;
    sum_t  new_ext;
    sum_t  sum_prime;
    sum_t  sum_next;
    sum_t  avg_full;
    temp_t avg_next;

    // A level held high counts once; clr overrides any accept.
    assign accept    = bus.rdy_in & ~rdy_q;
    assign do_prime  = accept & ~bus.clr & (state_q == EMPTY);
    assign do_update = accept & ~bus.clr & (state_q == RUN);

    tavg_ringbuf #(
        .DEPTH_LOG2 (AVG_LOG2)
    ) u_ringbuf (
        .clk   (clk),
        .fill  (do_prime),
        .we    (do_update),
        .ptr   (wr_ptr_q),
        .wdata (bus.temp_in),
        .rdata (old_sample)
    );

    always_comb begin
        old_ext   = {{AVG_LOG2{old_sample[TEMP_W-1]}}, old_sample};
        new_ext   = {{AVG_LOG2{bus.temp_in[TEMP_W-1]}}, bus.temp_in};
        sum_prime = new_ext <<< AVG_LOG2;
        sum_next  = sum_q - old_ext + new_ext;
        // Arithmetic shift floors toward -inf; the mean always fits TEMP_W.
        avg_full  = sum_next >>> AVG_LOG2;
        avg_next  = avg_full[TEMP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rdy_q      <= 1'b0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            temp_out_q <= '0;
            out_vld_q  <= 1'b0;
            primed_q   <= 1'b0;
`ifdef TAVG_MINMAX_EN
            tmin_q     <= '0;
            tmax_q     <= '0;
`endif
        end else begin
            rdy_q     <= bus.rdy_in;
            out_vld_q <= 1'b0;
            if (bus.clr) begin
                // Display keeps showing temp_out across a clear.
                state_q  <= EMPTY;
                primed_q <= 1'b0;
`ifdef TAVG_MINMAX_EN
                tmin_q   <= '0;
                tmax_q   <= '0;
`endif
            end else if (do_prime) begin
                state_q    <= RUN;
                sum_q      <= sum_prime;
                wr_ptr_q   <= '0;
                temp_out_q <= bus.temp_in;
                out_vld_q  <= 1'b1;
                primed_q   <= 1'b1;
`ifdef TAVG_MINMAX_EN
                tmin_q     <= bus.temp_in;
                tmax_q     <= bus.temp_in;
`endif
            end else if (do_update) begin
                sum_q      <= sum_next;
                wr_ptr_q   <= wr_ptr_q + ptr_t'(1);
                temp_out_q <= avg_next;
                out_vld_q  <= 1'b1;
`ifdef TAVG_MINMAX_EN
                if (avg_next < tmin_q) tmin_q <= avg_next;
                if (avg_next > tmax_q) tmax_q <= avg_next;
`endif
            end
        end
    end

    assign bus.temp_out = temp_out_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.primed   = primed_q;
`ifdef TAVG_MINMAX_EN
    assign bus.tmin     = tmin_q;
    assign bus.tmax     = tmax_q;
`endif

endmodule

// File: tb/tb_temp_avg_filter.sv
// Testbench: tb_temp_avg_filter
// Directed checks of temp_avg_filter with AVG_LOG2=3 (8-deep window).
// Values are in 1/16 degC. Min/max checks are built only with TAVG_MINMAX_EN.
module tb_temp_avg_filter;
    import tavg_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   vld_count;

    temp_avg_filter_if bus ();

    temp_avg_filter #(
        .AVG_LOG2 (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated rdy pulse; the update is visible right after the next edge.
    task automatic pulse(input int value, input int exp, input string tag);
        @(posedge clk); #1;
        bus.rdy_in  = 1'b1;
        bus.temp_in = temp_t'(value);
        @(posedge clk); #1;
        check({tag, "_vld"}, int'(bus.out_vld), 1);
        check({tag, "_out"}, int'(bus.temp_out), exp);
        bus.rdy_in = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.rdy_in  = 1'b0;
        bus.temp_in = '0;
        bus.clr     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", int'(bus.temp_out), 0);
        check("rst_vld", int'(bus.out_vld), 0);
        check("rst_primed", int'(bus.primed), 0);
        rst_n = 1'b1;

        // 1: prime at 400
        pulse(400, 400, "prime400");
        check("prime400_primed", int'(bus.primed), 1);
        @(posedge clk); #1;
        check("vld_one_cycle", int'(bus.out_vld), 0);
        check("hold_out", int'(bus.temp_out), 400);
`ifdef TAVG_MINMAX_EN
        check("mm_prime_min", int'(bus.tmin), 400);
        check("mm_prime_max", int'(bus.tmax), 400);
`endif

        // 2: step response 400 -> 560 across the full window
        for (int k = 1; k <= 8; k++) begin
            pulse(560, 400 + 20 * k, $sformatf("step%0d", k));
        end
        pulse(560, 560, "step9");
`ifdef TAVG_MINMAX_EN
        check("mm_step_min", int'(bus.tmin), 400);
        check("mm_step_max", int'(bus.tmax), 560);
        do_clear();
        check("mm_clr_min", int'(bus.tmin), 0);
        check("mm_clr_max", int'(bus.tmax), 0);
        pulse(-32, -32, "mm_neg");
        check("mm_neg_min", int'(bus.tmin), -32);
        check("mm_neg_max", int'(bus.tmax), -32);
`endif

        // 3: negative values floor toward -inf
        do_clear();
        check("clr_primed", int'(bus.primed), 0);
        check("clr_hold_out", int'(bus.temp_out), int'(bus.temp_out));
        pulse(0, 0, "prime0");
        pulse(-1, -1, "floor_neg1");
        do_clear();
        pulse(-168, -168, "prime_m168");
        pulse(-168, -168, "steady_m168");

        // 4: rdy held high with changing data -> one update, first value only
        do_clear();
        vld_count = 0;
        @(posedge clk); #1;
        bus.rdy_in  = 1'b1;
        bus.temp_in = temp_t'(320);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_vld) vld_count++;
            bus.temp_in = temp_t'(320 + 16 * (i + 1));
        end
        bus.rdy_in = 1'b0;
        check("held_vld_count", vld_count, 1);
        check("held_out", int'(bus.temp_out), 320);

        // 5: clr in the same cycle as accept drops the sample
        @(posedge clk); #1;
        bus.rdy_in  = 1'b1;
        bus.clr     = 1'b1;
        bus.temp_in = temp_t'(999);
        @(posedge clk); #1;
        bus.rdy_in = 1'b0;
        bus.clr    = 1'b0;
        check("clr_acc_vld", int'(bus.out_vld), 0);
        check("clr_acc_primed", int'(bus.primed), 0);
        check("clr_acc_out", int'(bus.temp_out), 320);
        pulse(80, 80, "reprime80");
        check("reprime80_primed", int'(bus.primed), 1);

        // Reset with rdy_in still high: accepted as a fresh edge afterwards
        @(posedge clk); #1;
        bus.rdy_in  = 1'b1;
        bus.temp_in = temp_t'(240);
        rst_n       = 1'b0;
        @(posedge clk); #1;
        check("midrst_out", int'(bus.temp_out), 0);
        check("midrst_primed", int'(bus.primed), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_vld", int'(bus.out_vld), 1);
        check("postrst_out", int'(bus.temp_out), 240);
        bus.rdy_in = 1'b0;
        pulse(400, 260, "postrst_upd");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
